inst_mem_responder: RTL and testbench

//  Instruction-memory responder on the far end of the IF fetch interface.

---
 rtl/inst_mem_responder.sv | 103 ++++++++++
 tb/tb_inst_mem_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: one fetch in flight, returns the word LATENCY cycles after accept.
// Response regs hold under backpressure; req_ready is high only while IDLE, so accepts never overlap.
module inst_mem_responder #(
    parameter int                 ADDR_W  = 64,
    parameter int                 DEPTH   = 1024,
    parameter logic [ADDR_W-1:0]  BASE    = ADDR_W'(64'h8000_0000),
    parameter int                 LATENCY = 1,
    localparam int                IDX_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_inst,
    output logic              resp_err,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic [31:0]       ld_data
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        mem [DEPTH];
    logic [ADDR_W-1:0]  off;
    logic [ADDR_W-3:0]  word;
    logic [IDX_W-1:0]   lat_idx, rd_idx;
    logic               lat_err, cur_err, err_sel;
    logic               accept, hs, enter_resp;

    // Index arithmetic wraps modulo 2^ADDR_W, so addresses below BASE show up as huge indices too.
    assign off     = req_addr - BASE;
    assign word    = off[ADDR_W-1:2];
    assign cur_err = (req_addr[1:0] != 2'b00) || (req_addr < BASE) ||
                     (word >= (ADDR_W-2)'(DEPTH));

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign hs        = resp_valid && resp_ready;

    // With LATENCY==1 the response is captured on the accept edge itself, straight from req_addr.
    assign rd_idx  = (state == IDLE) ? word[IDX_W-1:0] : lat_idx;
    assign err_sel = (state == IDLE) ? cur_err : lat_err;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt == CNT_W'(1)) state_nxt = RESP;
            RESP:    if (hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_resp = (state != RESP) && (state_nxt == RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                cnt <= CNT_W'(LATENCY - 1);
            else if (state == WAIT)
                cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_idx <= word[IDX_W-1:0];
            lat_err <= cur_err;
        end
    end

    // Read happens on the RESP-entry edge, so a same-edge load write is not seen but earlier ones are.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_inst  <= 32'h0;
            resp_err   <= 1'b0;
        end else if (enter_resp) begin
            resp_valid <= 1'b1;
            resp_inst  <= err_sel ? 32'h0 : mem[rd_idx];
            resp_err   <= err_sel;
        end else if (hs) begin
            resp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_en)
            mem[ld_idx] <= ld_data;
    end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: two instances (LATENCY 1 and 3) sharing clock, reset and load port.
// Expectations come from a vector table and hand sequences, carried to the response via a queue.
module tb_inst_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_en;
    logic [9:0]  ld_idx;
    logic [31:0] ld_data;

    logic        a_rv, a_rr, a_pv, a_pr, a_err;
    logic [63:0] a_addr;
    logic [31:0] a_inst;
    logic        b_rv, b_rr, b_pv, b_pr, b_err;
    logic [63:0] b_addr;
    logic [31:0] b_inst;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    vec_t        tbl [9];
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;

    inst_mem_responder #(.LATENCY(1)) u_a (
        .clk(clk), .rst(rst),
        .req_valid(a_rv), .req_ready(a_rr), .req_addr(a_addr),
        .resp_valid(a_pv), .resp_ready(a_pr), .resp_inst(a_inst), .resp_err(a_err),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
    );

    inst_mem_responder #(.LATENCY(3)) u_b (
        .clk(clk), .rst(rst),
        .req_valid(b_rv), .req_ready(b_rr), .req_addr(b_addr),
        .resp_valid(b_pv), .resp_ready(b_pr), .resp_inst(b_inst), .resp_err(b_err),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic pv(input bit s);
        return s ? b_pv : a_pv;
    endfunction
    function automatic logic rr(input bit s);
        return s ? b_rr : a_rr;
    endfunction
    function automatic logic [31:0] pinst(input bit s);
        return s ? b_inst : a_inst;
    endfunction
    function automatic logic perr(input bit s);
        return s ? b_err : a_err;
    endfunction

    task automatic set_req(input bit s, input logic v, input logic [63:0] addr);
        if (s) begin b_rv = v; b_addr = addr; end
        else   begin a_rv = v; a_addr = addr; end
    endtask

    task automatic set_pr(input bit s, input logic v);
        if (s) b_pr = v; else a_pr = v;
    endtask

    task automatic ld(input int idx, input logic [31:0] data);
        ld_en = 1'b1; ld_idx = 10'(idx); ld_data = data;
        step();
        ld_en = 1'b0;
    endtask

    // One fetch on instance s; optional load write to the fetched index at sample wr_at after accept,
    // optional hold cycles of resp_ready=0 with a competing request that must be ignored.
    task automatic xact(input bit s, input logic [63:0] addr, input logic [31:0] ei, input logic ee,
                        input int hold, input int wr_at, input logic [31:0] wr_data);
        int lat;
        logic [32:0] e;
        logic [31:0] held_inst;
        logic        held_err;
        set_req(s, 1'b1, addr);
        chk("req_ready_idle", 64'(rr(s)), 64'd1);
        exp_q.push_back({ee, ei});
        step();
        set_req(s, 1'b0, {$urandom, $urandom});
        lat = 1;
        while (!pv(s) && lat < 20) begin
            chk("req_ready_busy", 64'(rr(s)), 64'd0);
            if (lat == wr_at) begin
                ld_en = 1'b1; ld_idx = 10'((addr - 64'h8000_0000) >> 2); ld_data = wr_data;
            end else begin
                ld_en = 1'b0;
            end
            step();
            lat++;
        end
        ld_en = 1'b0;
        chk("latency", 64'(lat), s ? 64'd3 : 64'd1);
        if (hold > 0) begin
            set_pr(s, 1'b0);
            held_inst = pinst(s);
            held_err  = perr(s);
            set_req(s, 1'b1, 64'h8000_0008);
            for (int i = 0; i < hold; i++) begin
                step();
                chk("hold_valid", 64'(pv(s)), 64'd1);
                chk("hold_inst", 64'(pinst(s)), 64'(held_inst));
                chk("hold_err", 64'(perr(s)), 64'(held_err));
                chk("hold_req_ready", 64'(rr(s)), 64'd0);
            end
            set_req(s, 1'b0, 64'h0);
            set_pr(s, 1'b1);
        end
        if (exp_q.size() == 0) begin
            chk("queue_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk("resp_inst", 64'(pinst(s)), 64'(e[31:0]));
            chk("resp_err", 64'(perr(s)), 64'(e[32]));
        end
        step();
        chk("valid_after_hs", 64'(pv(s)), 64'd0);
        chk("ready_after_hs", 64'(rr(s)), 64'd1);
    endtask

    initial begin
        rst = 1'b1; ld_en = 1'b0; ld_idx = '0; ld_data = '0;
        a_rv = 1'b0; a_addr = '0; a_pr = 1'b1;
        b_rv = 1'b0; b_addr = '0; b_pr = 1'b1;

        // Load port works during reset as well.
        ld(0, 32'h0000_0413);
        ld(1, 32'h0010_0073);
        rst = 1'b0;
        chk("rst_valid", 64'(a_pv), 64'd0);
        chk("rst_inst", 64'(a_inst), 64'd0);
        chk("rst_err", 64'(a_err), 64'd0);
        chk("rst_ready", 64'(a_rr), 64'd1);
        chk("rst_valid_b", 64'(b_pv), 64'd0);
        ld(2, 32'h1234_0002);
        ld(5, 32'h5555_5555);
        ld(1023, 32'hCAFE_F00D);

        tbl[0] = '{64'h8000_0000, 32'h0000_0413, 1'b0};
        tbl[1] = '{64'h8000_0004, 32'h0010_0073, 1'b0};
        tbl[2] = '{64'h8000_0002, 32'h0000_0000, 1'b1};
        tbl[3] = '{64'h8000_1000, 32'h0000_0000, 1'b1};
        tbl[4] = '{64'h7FFF_FFFC, 32'h0000_0000, 1'b1};
        tbl[5] = '{64'h8000_0FFC, 32'hCAFE_F00D, 1'b0};
        tbl[6] = '{64'h8000_0008, 32'h1234_0002, 1'b0};
        tbl[7] = '{64'h0000_0001_8000_0000, 32'h0000_0000, 1'b1};
        tbl[8] = '{64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0000, 1'b1};

        for (int i = 0; i < 9; i++)
            xact(1'b0, tbl[i].addr, tbl[i].inst, tbl[i].err, 0, 0, 32'h0);
        for (int i = 0; i < 4; i++)
            xact(1'b1, tbl[i].addr, tbl[i].inst, tbl[i].err, 0, 0, 32'h0);

        // Backpressure on both latencies.
        xact(1'b0, 64'h8000_0004, 32'h0010_0073, 1'b0, 5, 0, 32'h0);
        xact(1'b1, 64'h8000_0002, 32'h0000_0000, 1'b1, 5, 0, 32'h0);

        // Write during WAIT is seen; write on the RESP-entry edge is not.
        xact(1'b1, 64'h8000_0014, 32'hDEAD_BEEF, 1'b0, 0, 1, 32'hDEAD_BEEF);
        xact(1'b1, 64'h8000_0014, 32'hDEAD_BEEF, 1'b0, 0, 2, 32'h1234_5678);

        // Reset while in WAIT drops the request but keeps the array.
        set_req(1'b1, 1'b1, 64'h8000_0014);
        step();
        set_req(1'b1, 1'b0, 64'h0);
        chk("wait_busy", 64'(b_rr), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_ready", 64'(b_rr), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_resp", 64'(b_pv), 64'd0);
            step();
        end
        xact(1'b1, 64'h8000_0014, 32'h1234_5678, 1'b0, 0, 0, 32'h0);
        xact(1'b0, 64'h8000_0000, 32'h0000_0413, 1'b0, 0, 0, 32'h0);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
